// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_BYPASS   = 1;
  localparam int DEF_INIT_IDX = 1;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination tracker: one pend bit per register, issue handshake
// and a running count of outstanding reservations.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEPTH - 1,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             iss_v,
  input  logic [AW-1:0]    iss_a,
  output logic             iss_rdy,
  output logic [DEPTH-1:0] pend,
  output logic [AW:0]      pend_cnt
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_nxt_s;
  logic [AW:0]      cnt_r;
  logic [AW:0]      cnt_nxt_s;
  logic             iss_rdy_s;
  logic             set_s;
  logic             clr_s;
  logic             inc_s;

  // Issue acceptance, set/clear decode and next pend/count values.
  always_comb begin
    iss_rdy_s  = (iss_a == ZERO_IDX) || !pend_r[iss_a] || (we && (wa == iss_a));
    set_s      = iss_v && iss_rdy_s && (iss_a != ZERO_IDX);
    // A set on the index being written wins, so that write is not a clear.
    clr_s      = we && pend_r[wa] && !(set_s && (iss_a == wa));
    inc_s      = set_s && !pend_r[iss_a];
    pend_nxt_s = pend_r;
    if (clr_s) begin
      pend_nxt_s[wa] = 1'b0;
    end else begin
      pend_nxt_s[wa] = pend_r[wa];
    end
    if (set_s) begin
      pend_nxt_s[iss_a] = 1'b1;
    end else begin
      pend_nxt_s[iss_a] = pend_nxt_s[iss_a];
    end
    pend_nxt_s[ZERO_IDX] = 1'b0;
    case ({inc_s, clr_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Pending state register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r <= {DEPTH{1'b0}};
      cnt_r  <= {(AW+1){1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign iss_rdy  = iss_rdy_s;
  assign pend     = pend_r;
  assign pend_cnt = cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a hardwired zero register, optional
// write-to-read forwarding and a destination scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = DEPTH - 1,
  parameter int BYPASS   = DEF_BYPASS,
  parameter int INIT_IDX = DEF_INIT_IDX,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREAD-1:0][AW-1:0]    ra,
  output logic [NREAD-1:0][WIDTH-1:0] rd,
  output logic [NREAD-1:0]            busy,
  input  logic                        we,
  input  logic [AW-1:0]               wa,
  input  logic [WIDTH-1:0]            wd,
  input  logic                        iss_v,
  input  logic [AW-1:0]               iss_a,
  output logic                        iss_rdy,
  output logic [AW:0]                 pend_cnt
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] pend_s;

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wa       (wa),
    .iss_v    (iss_v),
    .iss_a    (iss_a),
    .iss_rdy  (iss_rdy),
    .pend     (pend_s),
    .pend_cnt (pend_cnt)
  );

  // Data array; reset loads either the register index or zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= (INIT_IDX != 0) ? WIDTH'(i) : {WIDTH{1'b0}};
      end
    end else if (we && (wa != ZERO_IDX)) begin
      mem_r[wa] <= wd;
    end
  end

  // Combinational read ports with forwarding and pending visibility.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rd[i]   = {WIDTH{1'b0}};
      busy[i] = 1'b0;
      if (ra[i] == ZERO_IDX) begin
        rd[i]   = {WIDTH{1'b0}};
        busy[i] = 1'b0;
      end else if ((BYPASS != 0) && we && (wa == ra[i])) begin
        // The in-flight write both supplies the data and retires the hazard.
        rd[i]   = wd;
        busy[i] = 1'b0;
      end else begin
        rd[i]   = mem_r[ra[i]];
        busy[i] = pend_s[ra[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a forwarding and a non-forwarding instance
// share stimulus and are checked against an array-level reference model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int W  = 64;
  localparam int D  = 32;
  localparam int N  = 2;
  localparam int AW = 5;
  localparam int ZR = 31;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                we = 1'b0;
  logic                iss_v = 1'b0;
  logic [AW-1:0]       wa = '0;
  logic [AW-1:0]       iss_a = '0;
  logic [W-1:0]        wd = '0;
  logic [N-1:0][AW-1:0] ra = '0;

  logic [N-1:0][W-1:0] rd_b1, rd_b0;
  logic [N-1:0]        busy_b1, busy_b0;
  logic                rdy_b1, rdy_b0;
  logic [AW:0]         cnt_b1, cnt_b0;

  regfile_sb u_dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b1), .busy(busy_b1),
    .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_a(iss_a),
    .iss_rdy(rdy_b1), .pend_cnt(cnt_b1)
  );

  regfile_sb #(.BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b0), .busy(busy_b0),
    .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_a(iss_a),
    .iss_rdy(rdy_b0), .pend_cnt(cnt_b0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0][W-1:0] rd1;
    logic [N-1:0][W-1:0] rd0;
    logic [N-1:0]        busy1;
    logic [N-1:0]        busy0;
    logic                rdy;
    logic [AW:0]         cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: plain register array plus a set of reserved indices.
  logic [W-1:0] m_mem [D];
  bit           m_pend [D];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < D; i++) begin
      m_mem[i]  = W'(i);
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic bit model_rdy();
    return (iss_a == AW'(ZR)) || !m_pend[iss_a] || (we && (wa == iss_a));
  endfunction

  task automatic push_expect();
    exp_t e;
    int   n = 0;
    for (int i = 0; i < D; i++) n += int'(m_pend[i]);
    e.cnt = (AW+1)'(n);
    e.rdy = model_rdy();
    for (int p = 0; p < N; p++) begin
      logic [AW-1:0] r;
      bit fwd;
      r   = ra[p];
      fwd = we && (wa == r);
      if (r == AW'(ZR)) begin
        e.rd0[p] = '0; e.rd1[p] = '0; e.busy0[p] = 1'b0; e.busy1[p] = 1'b0;
      end else begin
        e.rd0[p]   = m_mem[r];
        e.rd1[p]   = fwd ? wd : m_mem[r];
        e.busy0[p] = m_pend[r];
        e.busy1[p] = m_pend[r] && !fwd;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    bit rdy;
    if (reset) begin
      model_reset();
    end else begin
      rdy = model_rdy();
      if (we && (wa != AW'(ZR))) m_mem[wa] = wd;
      if (we) m_pend[wa] = 1'b0;
      if (iss_v && rdy && (iss_a != AW'(ZR))) m_pend[iss_a] = 1'b1;
    end
  endtask

  task automatic apply(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic iv, input logic [AW-1:0] ia,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    we = w; wa = a; wd = d; iss_v = iv; iss_a = ia; ra[0] = r0; ra[1] = r1;
    push_expect();
    @(posedge clk);
    #1;
    model_step();
  endtask

  // Monitor: compares every queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int p = 0; p < N; p++) begin
        check($sformatf("rd_byp[%0d]", p),    rd_b1[p],          mon_e.rd1[p]);
        check($sformatf("rd_nobyp[%0d]", p),  rd_b0[p],          mon_e.rd0[p]);
        check($sformatf("busy_byp[%0d]", p),  W'(busy_b1[p]),    W'(mon_e.busy1[p]));
        check($sformatf("busy_nobyp[%0d]", p), W'(busy_b0[p]),   W'(mon_e.busy0[p]));
      end
      check("iss_rdy_byp",    W'(rdy_b1), W'(mon_e.rdy));
      check("iss_rdy_nobyp",  W'(rdy_b0), W'(mon_e.rdy));
      check("pend_cnt_byp",   W'(cnt_b1), W'(mon_e.cnt));
      check("pend_cnt_nobyp", W'(cnt_b0), W'(mon_e.cnt));
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    // Held reset: writes and issues ignored, index values visible.
    apply(1'b1, 5'd4, 64'h55, 1'b1, 5'd6, 5'd5, 5'd31);
    apply(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd4, 5'd6);
    reset = 1'b0;
    apply(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd31);

    // Same-cycle forwarding, then the stored value.
    apply(1'b1, 5'd3, 64'hABCD, 1'b0, 5'd0, 5'd3, 5'd0);
    apply(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd3, 5'd3);

    // Reserve 7, blocked re-issue, clear via write.
    apply(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 5'd0, 5'd0);
    apply(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 5'd0, 5'd7);
    apply(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 5'd0, 5'd7);
    apply(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd7);

    // Write and re-issue of pending 9 in one cycle: set wins.
    apply(1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 5'd0, 5'd0);
    apply(1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 5'd9, 5'd9);
    apply(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    apply(1'b1, 5'd9, 64'h9A, 1'b0, 5'd0, 5'd9, 5'd0);

    // Zero register: write discarded, issue always accepted, never pending.
    apply(1'b1, 5'd31, 64'hFF, 1'b0, 5'd0, 5'd31, 5'd31);
    apply(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 5'd31, 5'd0);
    apply(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd31, 5'd31);

    // Five reservations, then reset asserted between edges.
    for (int k = 1; k <= 5; k++) apply(1'b0, 5'd0, 64'h0, 1'b1, AW'(k), 5'd0, 5'd0);
    apply(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd3, 5'd5);
    reset = 1'b1;
    model_reset();
    apply(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd3, 5'd5);
    apply(1'b1, 5'd2, 64'h22, 1'b1, 5'd2, 5'd2, 5'd4);
    reset = 1'b0;

    // Randomized traffic concentrated on a few indices to provoke collisions.
    for (int c = 0; c < 400; c++) begin
      logic [AW-1:0] a [4];
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       a[k] = AW'(ZR);
          1:       a[k] = AW'($urandom_range(0, 31));
          default: a[k] = AW'($urandom_range(0, 7));
        endcase
      end
      apply($urandom_range(0, 2) == 0, a[0], {$urandom, $urandom},
            $urandom_range(0, 1) == 1, a[1], a[2], a[3]);
    end

    we = 1'b0;
    iss_v = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be:
- WIDTH, 64, data width in bits.
- DEPTH, 32, number of registers (power of two, >=4); AW = log2(DEPTH).
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, DEPTH-1, index that always reads 0.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding.
- INIT_IDX, 1, 1 = register i resets to value i; 0 = resets to 0.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, async active-high reset.
- ra, in, NREAD x AW, read addresses.
- rd, out, NREAD x WIDTH, read data.
- busy, out, NREAD, per-port pending flag.
- we, in, 1, write enable.
- wa, in, AW, write address.
- wd, in, WIDTH, write data.
- iss_v, in, 1, issue request: reserve destination iss_a.
- iss_a, in, AW, destination being reserved.
- iss_rdy, out, 1, issue accepted this cycle.
- pend_cnt, out, AW+1, number of pending registers.

Function
REQ-004 rd[i] SHALL be combinational: 0 if ra[i]==ZERO_REG; else wd if BYPASS==1 and we and wa==ra[i]; else the stored value of ra[i].
REQ-005 The block SHALL store wd into register wa on rising clk when we==1 and wa!=ZERO_REG; writes to ZERO_REG SHALL be discarded.
REQ-006 The block SHALL keep one pending bit per register; the ZERO_REG pending bit SHALL be constant 0.
REQ-007 iss_rdy SHALL be 1 when iss_a==ZERO_REG, or when pend[iss_a]==0, or when we and wa==iss_a (clear in the same cycle); otherwise 0, which blocks WAW reservation.
REQ-008 On rising clk with iss_v and iss_rdy and iss_a!=ZERO_REG, pend[iss_a] SHALL become 1.
REQ-009 On rising clk with we, pend[wa] SHALL become 0, unless REQ-008 sets the same index that cycle; the set SHALL win.
REQ-010 busy[i] SHALL be: pend[ra[i]] and not (BYPASS==1 and we and wa==ra[i]); busy[i] SHALL be 0 for ZERO_REG.
REQ-011 pend_cnt SHALL equal the popcount of pend and update on the same edge as pend.
- It SHALL be a registered counter: +1 on set, -1 on clear, net 0 when both hit distinct indices.
- It SHALL never exceed DEPTH-1.
REQ-012 A write with we to a non-pending register SHALL update data and leave pend and pend_cnt unchanged.
REQ-013 All address inputs SHALL be full-range; no address is out of range by construction.

Reset
REQ-014 While reset==1, stored register i SHALL hold i (INIT_IDX==1) or 0 (INIT_IDX==0), truncated to WIDTH.
REQ-015 While reset==1, all pending bits and pend_cnt SHALL be 0; busy SHALL be 0 for all ports.
REQ-016 While reset==1, writes and issues SHALL be ignored; the first accepted operation SHALL occur on the first rising clk after reset deasserts.
REQ-017 Reset asserted mid-operation SHALL clear the pending state immediately, without waiting for a clock edge.

Structure
REQ-018 Package regfile_pkg SHALL hold the default parameter constants and an address-width function.
REQ-019 The pending bits, iss_rdy and pend_cnt logic SHALL live in sub-module regfile_scoreboard; the data array and read muxing SHALL stay in regfile_sb.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset with defaults -> rd for ra=5 is 5; ra=31 gives 0; pend_cnt=0; busy=0.
- we=1, wa=3, wd=0xABCD, ra[0]=3, same cycle -> rd[0]=0xABCD with BYPASS=1; with BYPASS=0, rd[0]=3 until after the edge.
- Issue iss_a=7, then ra[1]=7 -> busy[1]=1 and pend_cnt=1; next iss_a=7 gives iss_rdy=0; we to wa=7 -> busy clears and pend_cnt=0.
- Same cycle: we with wa=9 while issuing iss_a=9 (pend[9]=1) -> iss_rdy=1, pend[9] stays 1, pend_cnt unchanged.
- we to wa=31 with wd=0xFF, then issue iss_a=31 -> ra=31 reads 0, iss_rdy=1, pend_cnt stays 0.
- Set 5 pending, then assert reset between edges -> pend_cnt=0 and busy=0 immediately; registers return to index values.
